// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain host controller.
package scan_pkg;

   localparam int SCAN_BYTE_W = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_EMIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_LOAD  = ST_LOAD,
      S_SHIFT = ST_SHIFT,
      S_EMIT  = ST_EMIT,
      S_DONE  = ST_DONE
   } scan_state_e;

endpackage

// File: rtl/scan_byte_shifter.sv
// One byte of scan traffic: outgoing tx shifter, incoming capture shifter
// and the per-byte bit counter. cap_out is the captured bits left-aligned,
// so a short final byte comes out with zero LSBs.
module scan_byte_shifter
   import scan_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   shift,
   input  logic [SCAN_BYTE_W-1:0] din,
   input  logic                   sin,
   output logic                   sout,
   output logic [SCAN_BYTE_W-1:0] cap_out,
   output logic                   last_bit
);

   localparam int CNT_W = $clog2(SCAN_BYTE_W + 1);

   logic [SCAN_BYTE_W-1:0] tx;
   logic [SCAN_BYTE_W-1:0] cap;
   logic [CNT_W-1:0]       bit_cnt;

   // Load a new byte, or shift one bit out of tx and one bit into cap.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx      <= '0;
         cap     <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         tx      <= din;
         bit_cnt <= '0;
      end else if (shift) begin
         tx      <= tx << 1;
         cap     <= {cap[SCAN_BYTE_W-2:0], sin};
         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   assign sout     = tx[SCAN_BYTE_W-1];
   assign last_bit = (bit_cnt == CNT_W'(SCAN_BYTE_W - 1));
   assign cap_out  = cap << (CNT_W'(SCAN_BYTE_W) - bit_cnt);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Byte-wide host controller for the processor scan chain.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for start; pass bit counter cleared
//  LOAD  | in_ready high, waiting for the next input byte
//  SHIFT | scan_enable high, one chain bit in and one out per cycle
//  EMIT  | out_valid high, holding the captured byte until accepted
//  DONE  | one-cycle done pulse, then back to IDLE
module scan_chain_ctrl
   import scan_pkg::*;
#(
   parameter int CHAIN_LEN = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [SCAN_BYTE_W-1:0] in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [SCAN_BYTE_W-1:0] out_data,
   input  logic                   out_ready,
   output logic                   scan_enable,
   output logic                   scan_in,
   input  logic                   scan_out,
   output logic                   busy,
   output logic                   done
);

   localparam int            TW     = $clog2(CHAIN_LEN + 1);
   localparam logic [TW-1:0] LEN_T  = TW'(CHAIN_LEN);
   localparam logic [TW-1:0] LEN_M1 = TW'(CHAIN_LEN - 1);

   scan_state_e            state, state_nxt;
   logic [TW-1:0]          total_cnt;
   logic                   sh_load, sh_shift, sh_sout, sh_last;
   logic [SCAN_BYTE_W-1:0] sh_cap;

   scan_byte_shifter u_shifter (
      .clk      (clk),
      .rst      (rst),
      .load     (sh_load),
      .shift    (sh_shift),
      .din      (in_data),
      .sin      (scan_out),
      .sout     (sh_sout),
      .cap_out  (sh_cap),
      .last_bit (sh_last)
   );

   // State register and whole-pass bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         total_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE)
            total_cnt <= '0;
         else if (state == S_SHIFT)
            total_cnt <= total_cnt + TW'(1);
      end
   end

   // Next-state decode; leave SHIFT on a full byte or at the chain end.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  if (in_valid) state_nxt = S_SHIFT;
         S_SHIFT: if (sh_last || (total_cnt == LEN_M1)) state_nxt = S_EMIT;
         S_EMIT:  if (out_ready) state_nxt = (total_cnt == LEN_T) ? S_DONE : S_LOAD;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign sh_load  = (state == S_LOAD) && in_valid;
   assign sh_shift = (state == S_SHIFT);

   assign in_ready    = (state == S_LOAD);
   assign out_valid   = (state == S_EMIT);
   assign out_data    = (state == S_EMIT) ? sh_cap : '0;
   assign scan_enable = sh_shift;
   assign scan_in     = sh_shift & sh_sout;
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);

endmodule
